// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, one-entry skid buffer and IF/ID register.
// A redirect seen while a fetch is outstanding waits for that fetch and then discards it.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HELD = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;

  logic [31:0] target;
  logic [31:0] pc_inc;
  logic        unused_ok;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign pc_inc    = pc_q + 32'd4;
  assign unused_ok = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          state_d = imem_ready ? RUN : DROP;
        end else if (stall && imem_ready) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (redirect || !stall) begin
          state_d = RUN;
        end
      end
      DROP: begin
        if (imem_ready) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    imem_req  = !rst && (state_q != HELD);
    imem_addr = pc_q;
  end

  always_comb begin
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    id_valid_d  = id_valid_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    unique case (state_q)
      RUN: begin
        if (redirect) begin
          id_valid_d = 1'b0;
          id_instr_d = 32'h0;
          if (imem_ready) begin
            pc_d = target;
          end else begin
            tgt_d = target;
          end
        end else if (!stall) begin
          if (imem_ready) begin
            id_valid_d = 1'b1;
            id_instr_d = imem_rdata;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_inc;
            pc_d       = pc_inc;
          end else begin
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
          end
        end else if (imem_ready) begin
          buf_instr_d = imem_rdata;
          buf_pc_d    = pc_q;
          pc_d        = pc_inc;
        end
      end
      HELD: begin
        if (redirect) begin
          buf_instr_d = 32'h0;
          buf_pc_d    = 32'h0;
          id_valid_d  = 1'b0;
          id_instr_d  = 32'h0;
          pc_d        = target;
        end else if (!stall) begin
          id_valid_d = 1'b1;
          id_instr_d = buf_instr_q;
          id_pc_d    = buf_pc_q;
          id_pc4_d   = buf_pc_q + 32'd4;
        end
      end
      DROP: begin
        id_valid_d = 1'b0;
        id_instr_d = 32'h0;
        if (redirect) begin
          tgt_d = target;
        end
        // a redirect in the completing cycle is the newest target
        if (imem_ready) begin
          pc_d = redirect ? target : tgt_q;
        end
      end
      default: begin
        id_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      tgt_q       <= 32'h0;
      buf_instr_q <= 32'h0;
      buf_pc_q    <= 32'h0;
      id_valid_q  <= 1'b0;
      id_instr_q  <= 32'h0;
      id_pc_q     <= 32'h0;
      id_pc4_q    <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      tgt_q       <= tgt_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      id_valid_q  <= id_valid_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc    = id_pc_q;
  assign id_pc4   = id_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: expected IF/ID words are queued when the
// response is driven and popped when a fresh valid instruction appears.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc4     (id_pc4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    q.push_back(e);
  endtask

  // IF/ID only loads a new word when stall was low at the edge.
  task automatic tick();
    logic st;
    exp_t e;
    st = stall;
    @(posedge clk);
    #1;
    if (id_valid === 1'b1 && !st) begin
      if (q.size() == 0) begin
        chk("spurious_valid", {31'b0, id_valid}, 32'h0);
      end else begin
        e = q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_instr", id_instr, e.instr);
        chk("sb_pc4", id_pc4, e.pc + 32'd4);
      end
    end
  endtask

  task automatic drive(input logic st, input logic rd,
                       input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] data);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = data;
    #1;
  endtask

  task automatic req_at(input string tag, input logic [31:0] addr);
    chk({tag, "_req"}, {31'b0, imem_req}, 32'h1);
    chk({tag, "_addr"}, imem_addr, addr);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_pc4", id_pc4, 32'h0);

    // streaming
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h11);
    req_at("s0", 32'h0);
    push(32'h0, 32'h11);
    tick();
    chk("s0_valid", {31'b0, id_valid}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h22);
    req_at("s1", 32'h4);
    push(32'h4, 32'h22);
    tick();
    chk("s1_valid", {31'b0, id_valid}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h33);
    req_at("s2", 32'h8);
    push(32'h8, 32'h33);
    tick();
    chk("s2_valid", {31'b0, id_valid}, 32'h1);

    // redirect with immediate ready; low target bits ignored
    drive(1'b0, 1'b1, 32'h7, 1'b1, 32'hDEAD);
    req_at("rr", 32'hC);
    tick();
    chk("rr_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h44);
    req_at("rr_tgt", 32'h4);
    push(32'h4, 32'h44);
    tick();

    // stall with response at 0x8
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h88);
    req_at("st0", 32'h8);
    tick();
    chk("st0_pc", id_pc, 32'h4);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("st1_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("st2_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("st_hold_pc", id_pc, 32'h4);
    chk("st_hold_instr", id_instr, 32'h44);
    chk("st_hold_valid", {31'b0, id_valid}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("st3_req", {31'b0, imem_req}, 32'h0);
    push(32'h8, 32'h88);
    tick();
    chk("st_rel_valid", {31'b0, id_valid}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hCC);
    req_at("st_next", 32'hC);
    push(32'hC, 32'hCC);
    tick();

    // redirect during a wait at 0x10
    drive(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
    req_at("dw0", 32'h10);
    tick();
    chk("dw0_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    req_at("dw1", 32'h10);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD0);
    req_at("dw2", 32'h10);
    tick();
    chk("dw_drop_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1000);
    req_at("dw_tgt", 32'h100);
    push(32'h100, 32'h1000);
    tick();

    // redirect while HELD
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBAD1);
    req_at("hd0", 32'h104);
    tick();
    drive(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("hd1_req", {31'b0, imem_req}, 32'h0);
    tick();
    chk("hd_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2000);
    req_at("hd_tgt", 32'h200);
    push(32'h200, 32'h2000);
    tick();

    // double redirect in DROP
    drive(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
    req_at("dd0", 32'h204);
    tick();
    drive(1'b0, 1'b1, 32'h400, 1'b0, 32'h0);
    req_at("dd1", 32'h204);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hBAD2);
    req_at("dd2", 32'h204);
    tick();
    chk("dd_valid", {31'b0, id_valid}, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4000);
    req_at("dd_tgt", 32'h400);
    push(32'h400, 32'h4000);
    tick();

    // wrap, then reset mid-request
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hBAD3);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hF0);
    req_at("wr", 32'hFFFF_FFFC);
    push(32'hFFFF_FFFC, 32'hF0);
    tick();
    chk("wr_pc4", id_pc4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    req_at("wr_next", 32'h0);
    tick();
    drive(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("rst2_req", {31'b0, imem_req}, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    req_at("rst2", 32'h0);
    chk("rst2_valid", {31'b0, id_valid}, 32'h0);
    chk("rst2_instr", id_instr, 32'h0);
    chk("rst2_pc", id_pc, 32'h0);
    chk("rst2_pc4", id_pc4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h55);
    push(32'h0, 32'h55);
    tick();
    chk("sb_empty", q.size(), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the PC loaded at reset.
REQ-002 clk  input  1  Rising-edge clock; the block has one clock.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 stall  input  1  ID stage cannot accept a new instruction this cycle.
REQ-005 redirect  input  1  Taken branch or jump; flushes the wrong path.
REQ-006 redirect_pc  input  32  Branch or jump target; bits [1:0] are ignored and treated as 00.
REQ-007 imem_req  output  1  Instruction fetch request.
REQ-008 imem_addr  output  32  Fetch address; equals the current fetch PC.
REQ-009 imem_ready  input  1  Memory response; data is valid and the request completes in this same cycle.
REQ-010 imem_rdata  input  32  Instruction word; sampled only when imem_req and imem_ready are both 1.
REQ-011 id_valid  output  1  IF/ID register holds a valid instruction.
REQ-012 id_instr  output  32  IF/ID instruction word, feeding the decoder.
REQ-013 id_pc  output  32  Address of id_instr.
REQ-014 id_pc4  output  32  id_pc + 4.

Function
REQ-015 FSM states: RUN, HELD and DROP.
- RUN: normal fetch.
- HELD: one response is parked in the skid buffer.
- DROP: a wrong-path response is outstanding.
REQ-016 imem_req = 1 in RUN and DROP, 0 in HELD, and 0 whenever rst = 1.
REQ-017 Once imem_req = 1, imem_req and imem_addr stay stable until imem_ready, in every state, including across a redirect.
REQ-018 PC increment wraps modulo 2^32; id_pc4 = id_pc + 4 with the same wrap.
REQ-019 RUN, redirect = 0, stall = 0, imem_ready = 1:
- id_valid <= 1, id_instr <= imem_rdata, id_pc <= pc, id_pc4 <= pc + 4.
- pc <= pc + 4.
REQ-020 RUN, redirect = 0, stall = 0, imem_ready = 0: load a bubble; id_valid <= 0 and id_instr <= 0 (NOP).
REQ-021 RUN, redirect = 0, stall = 1:
- IF/ID registers hold.
- If imem_ready = 1: skid buffer <= {imem_rdata, pc}, pc <= pc + 4, state -> HELD.
REQ-022 HELD, redirect = 0:
- stall = 1: hold everything.
- stall = 0: IF/ID <= buffer with id_valid = 1, state -> RUN.
- The first new request issues in the following cycle.
REQ-023 RUN with redirect = 1, which overrides stall:
- id_valid <= 0 and id_instr <= 0.
- If imem_ready = 1: discard the response, pc <= target, stay RUN.
- If imem_ready = 0: tgt <= target, state -> DROP.
REQ-024 DROP:
- imem_addr stays at the old pc; the outcome is forced to a bubble.
- imem_ready = 1: discard the data, pc <= tgt, state -> RUN.
- redirect = 1 in DROP: tgt <= the new target, the latest target wins.
REQ-025 HELD with redirect = 1: clear the buffer, id_valid <= 0, pc <= target, state -> RUN.
REQ-026 No wrong-path instruction ever reaches id_valid = 1 after a redirect is sampled.
REQ-027 Latency: a request accepted in cycle N appears on id_* in cycle N+1 when not stalled.
REQ-028 Throughput: 1 instruction per cycle when imem_ready is held at 1.

Reset
REQ-029 While rst = 1, at each rising edge:
- pc <= RESET_PC and state <= RUN.
- id_valid, id_instr, id_pc and id_pc4 <= 0; the skid buffer and tgt are cleared.
REQ-030 A reset asserted mid-request or in DROP abandons the outstanding request.
REQ-031 The first request issues in the first cycle after rst deasserts, with imem_addr = RESET_PC.

Verification
REQ-032 Streaming:
- Stimulus: imem_ready = 1 every cycle, no stall; returned words 0x11, 0x22, 0x33.
- Required: id_pc = 0x0, 0x4, 0x8 on consecutive cycles, id_valid = 1 throughout.
REQ-033 Stall with response:
- Stimulus: stall = 1 for 3 cycles, response arrives at pc = 0x8.
- Required: state HELD, imem_req = 0, IF/ID holds pc 0x4.
- After stall drops: id_pc = 0x8 next cycle, then a fetch at 0xC.
REQ-034 Redirect during a wait:
- Stimulus: redirect to 0x100 while imem_ready = 0 at pc = 0x10.
- Required: imem_addr stays 0x10 until ready, that response is dropped with id_valid = 0, then imem_addr = 0x100.
REQ-035 Redirect while HELD:
- Stimulus: redirect to 0x200 with stall = 1.
- Required: id_valid = 0 next cycle, buffer discarded, imem_addr = 0x200.
REQ-036 Double redirect in DROP:
- Stimulus: targets 0x300, then 0x400.
- Required: the fetch after the drop is at 0x400.
REQ-037 Wrap and reset:
- Stimulus: pc = 0xFFFF_FFFC, then assert rst mid-request.
- Required: id_pc4 = 0x0; after rst, all id_* = 0 and imem_addr = RESET_PC.
